pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage core. It replaces the fixed-field stage registers with one generic payload bus per stage boundary, adding a valid/ready handshake, flush with bubble insertion, and an optional second "skid" entry that cuts the combinational ready path between stages. One instance sits at each of the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries; the decoder-side bundle is concatenated into the payload by the instantiating stage.

---
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and a saturating bubble counter.
// Define PIPE_SKID_EN for a two-entry skid build whose in_ready has no path from out_ready.
module pipe_stage_reg #(
  parameter int              DATA_W      = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit              FLUSH_CLEAR = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [DATA_W-1:0] data_q, data_d, flush_val;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_data   = data_q;
  assign bubble_cnt = cnt_q;
  assign flush_val  = FLUSH_CLEAR ? RESET_VAL : data_q;
  assign cnt_d      = (~out_valid & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  assign out_valid = state_q != EMPTY;
  assign in_ready  = ~stall & (state_q != TWO);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      data_d  = flush_val;
      skid_d  = FLUSH_CLEAR ? RESET_VAL : skid_q;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          data_d  = in_data;
        end
        ONE: if (in_fire & out_fire) data_d = in_data;
          else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) state_d = EMPTY;
        TWO: if (out_fire) begin
          state_d = ONE;
          data_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= EMPTY;
      data_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
`else
  logic valid_q, valid_d;

  assign out_valid = valid_q;
  assign in_ready  = ~stall & (~valid_q | out_ready);
  assign valid_d   = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;
  assign data_d    = flush ? flush_val : in_fire ? in_data : data_q;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-scoreboard bench for pipe_stage_reg, default or PIPE_SKID_EN build.
module tb_pipe_stage_reg;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic       clk = 1'b0, resetn = 1'b0;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic       stall = 1'b0, flush = 1'b0;
  logic [7:0] in_data = '0, out_data;
  logic [3:0] bubble_cnt;
  int         vectors = 0, errors = 0;
  logic [7:0] q[$];
  logic [3:0] mcnt = '0;

  pipe_stage_reg #(.DATA_W(8), .RESET_VAL(8'h00), .FLUSH_CLEAR(1'b1), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush(flush), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic s, input logic f);
    in_valid = v; in_data = d; out_ready = r; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue occupancy stands in for held entries.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      q.delete();
      mcnt = '0;
    end else begin
      automatic logic mv  = q.size() != 0;
      automatic logic rdy = !stall && (SKID ? q.size() < 2 : (!mv || out_ready));
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, mv);
      if (mv) check("out_data", out_data, q[0]);
      check("bubble_cnt", bubble_cnt, mcnt);
      if (!mv && mcnt != 4'hF) mcnt++;
      if (mv && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && rdy) q.push_back(in_data);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", bubble_cnt, 0);
    resetn = 1'b1;
    cyc(1, 8'hA5, 0, 0, 0);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    #1 resetn = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_cnt", bubble_cnt, 0);
    check("async_rdy", in_ready, 1);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1, 8'hA5, 1, 0, 0);
    check("post_rst_accept", out_data, 8'hA5);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 1, 0, 0);
      check("stream", out_data, i);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(1, 8'h11, 0, 0, 0);
    repeat (3) begin
      cyc(1, 8'h12, 0, 0, 0);
      check("bp_hold", out_data, 8'h11);
      check("bp_rdy", in_ready, 0);
    end
    if (SKID) cyc(0, 0, 1, 0, 0);
    else cyc(1, 8'h12, 1, 0, 0);
    check("bp_second", out_data, 8'h12);
    repeat (2) cyc(0, 0, 1, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    check("stall_load", out_data, 8'h22);
    cyc(1, 8'h99, 1, 1, 0);
    check("stall_bubble", out_valid, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 8'h31, 0, 0, 0);
    if (SKID) cyc(1, 8'h32, 0, 0, 0);
    cyc(1, 8'h33, 1, 0, 1);
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) cyc(0, 0, 0, 0, 0);
    check("cnt_sat", bubble_cnt, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
